// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Multiplexed hex driver for 1..8 seven-segment digits on a shared segment
//   bus. A hex word is captured on `load`. One digit is shown per time slot of
//   CLKS_PER_DIGIT clocks. The first GUARD_CLKS clocks of every slot are dark,
//   which stops the previous digit's pattern ghosting onto the next digit.
//   Options: leading-zero blanking, global blank, and per-bus output polarity.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   data_in     hex word, digit 0 = bits [3:0] (rightmost)
//   load        capture strobe for data_in
//   lz_blank    1 = suppress leading zeros (digit 0 is always shown)
//   blank       1 = all digits dark (scan keeps running)
//   seg         segments {a,b,c,d,e,f,g} = [6:0], polarity per SEG_ACTIVE_LOW
//   dig_en      one-hot digit enable, polarity per DIG_ACTIVE_LOW
//   frame_tick  one-cycle pulse after the last slot of each scan
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLKS_PER_DIGIT = 25000,
  parameter int GUARD_CLKS     = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    load,
  input  logic                    lz_blank,
  input  logic                    blank,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(CLKS_PER_DIGIT);

  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(CLKS_PER_DIGIT - 1);
  localparam logic [CNT_W-1:0]      CNT_GUARD = CNT_W'(GUARD_CLKS);
  // XOR masks: applying them to an active-high value yields the pin level,
  // and on their own they are the "everything off" pin level.
  localparam logic [6:0]            SEG_OFF   = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF   = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  logic [NUM_DIGITS-1:0][3:0] data_reg;
  logic [CNT_W-1:0]           cnt;
  logic [IDX_W-1:0]           idx;

  // Active-high segment code for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] c;
    case (h)
      4'h0: c = 7'h7E;  4'h1: c = 7'h30;  4'h2: c = 7'h6D;  4'h3: c = 7'h79;
      4'h4: c = 7'h33;  4'h5: c = 7'h5B;  4'h6: c = 7'h5F;  4'h7: c = 7'h70;
      4'h8: c = 7'h7F;  4'h9: c = 7'h7B;  4'hA: c = 7'h77;  4'hB: c = 7'h1F;
      4'hC: c = 7'h4E;  4'hD: c = 7'h3D;  4'hE: c = 7'h4F;  default: c = 7'h47;
    endcase
    return c;
  endfunction

  // zero_from[g] = nibbles g..NUM_DIGITS-1 are all zero. The chain runs from
  // the top digit down, and digit 0 is never part of it, so a zero value
  // still shows "0".
  logic [NUM_DIGITS:1]       zero_from;
  logic [NUM_DIGITS-1:0]     suppress;

  assign zero_from[NUM_DIGITS] = 1'b1;
  assign suppress[0]           = 1'b0;

  generate
    for (genvar g = NUM_DIGITS - 1; g >= 1; g--) begin : g_lz
      assign zero_from[g] = zero_from[g+1] && (data_reg[g] == 4'h0);
      assign suppress[g]  = zero_from[g];
    end
  endgenerate

  logic                  digit_on;
  logic [NUM_DIGITS-1:0] onehot;

  assign digit_on = (cnt >= CNT_GUARD) && !blank && !(lz_blank && suppress[idx]);
  assign onehot   = NUM_DIGITS'(1) << idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg   <= '0;
      cnt        <= '0;
      idx        <= '0;
      seg        <= SEG_OFF;
      dig_en     <= DIG_OFF;
      frame_tick <= 1'b0;
    end else begin
      if (load) data_reg <= data_in;

      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      frame_tick <= (cnt == CNT_LAST) && (idx == IDX_LAST);

      // seg and dig_en are written together from the same pre-edge idx, so a
      // pattern is never shown with a different digit enabled.
      if (digit_on) begin
        seg    <= hex7(data_reg[idx]) ^ SEG_OFF;
        dig_en <= onehot ^ DIG_OFF;
      end else begin
        seg    <= SEG_OFF;
        dig_en <= DIG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 4 digits, 8 clocks/slot, 2 guard clocks, active-low pins
  logic        rst_n;
  logic [15:0] data_in;
  logic        load, lz_blank, blank;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic        frame_tick;

  // DUT B: 1 digit, active-high pins
  logic [3:0]  data_in1;
  logic        load1, lz_blank1, blank1;
  logic [6:0]  seg1;
  logic [0:0]  dig_en1;
  logic        frame_tick1;

  seg7_scan_driver #(
    .NUM_DIGITS(4), .CLKS_PER_DIGIT(8), .GUARD_CLKS(2),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load),
    .lz_blank(lz_blank), .blank(blank), .seg(seg), .dig_en(dig_en),
    .frame_tick(frame_tick)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(1), .CLKS_PER_DIGIT(8), .GUARD_CLKS(2),
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in1), .load(load1),
    .lz_blank(lz_blank1), .blank(blank1), .seg(seg1), .dig_en(dig_en1),
    .frame_tick(frame_tick1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] d);
    data_in = d;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  // Returns #1 after the edge that raised frame_tick (scan is then at slot 0 cnt 0).
  task automatic wait_frame();
    bit got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      tick();
      got = frame_tick;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL frame_tick timeout: got none expected pulse within 100 cycles");
    end
  endtask

  typedef struct {
    logic [15:0] data;
    logic        lz;
    int          slot;
    int          c;
    logic [6:0]  seg;
    logic [3:0]  dig;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int first_ft, first_ft1;
    bit got1;

    rst_n = 1'b0; data_in = '0; load = 1'b0; lz_blank = 1'b0; blank = 1'b0;
    data_in1 = '0; load1 = 1'b0; lz_blank1 = 1'b0; blank1 = 1'b0;

    // active-low codes: 0=01 1=4F 2=12 3=06 4=4C 5=24 6=20 7=0F
    //                   8=00 9=04 A=08 B=60 C=31 D=42 E=30 F=38
    tbl.push_back('{16'h1A3F, 1'b0, 0, 0, 7'h7F, 4'hF});
    tbl.push_back('{16'h1A3F, 1'b0, 0, 2, 7'h38, 4'hE});
    tbl.push_back('{16'h1A3F, 1'b0, 1, 1, 7'h7F, 4'hF});
    tbl.push_back('{16'h1A3F, 1'b0, 1, 5, 7'h06, 4'hD});
    tbl.push_back('{16'h1A3F, 1'b0, 2, 7, 7'h08, 4'hB});
    tbl.push_back('{16'h1A3F, 1'b0, 3, 2, 7'h4F, 4'h7});
    tbl.push_back('{16'h0050, 1'b1, 3, 4, 7'h7F, 4'hF});
    tbl.push_back('{16'h0050, 1'b1, 2, 2, 7'h7F, 4'hF});
    tbl.push_back('{16'h0050, 1'b1, 2, 7, 7'h7F, 4'hF});
    tbl.push_back('{16'h0050, 1'b1, 1, 3, 7'h24, 4'hD});
    tbl.push_back('{16'h0050, 1'b1, 0, 6, 7'h01, 4'hE});
    tbl.push_back('{16'h0000, 1'b1, 0, 2, 7'h01, 4'hE});
    tbl.push_back('{16'h0000, 1'b1, 1, 4, 7'h7F, 4'hF});
    tbl.push_back('{16'h0000, 1'b1, 3, 7, 7'h7F, 4'hF});
    tbl.push_back('{16'h0000, 1'b0, 3, 3, 7'h01, 4'h7});
    tbl.push_back('{16'h0B0C, 1'b1, 0, 4, 7'h31, 4'hE});
    tbl.push_back('{16'h0B0C, 1'b1, 1, 4, 7'h01, 4'hD});
    tbl.push_back('{16'h0B0C, 1'b1, 2, 4, 7'h60, 4'hB});
    tbl.push_back('{16'h0B0C, 1'b1, 3, 4, 7'h7F, 4'hF});
    tbl.push_back('{16'h2468, 1'b0, 0, 3, 7'h00, 4'hE});
    tbl.push_back('{16'h2468, 1'b0, 1, 3, 7'h20, 4'hD});
    tbl.push_back('{16'h2468, 1'b0, 2, 3, 7'h4C, 4'hB});
    tbl.push_back('{16'h2468, 1'b0, 3, 3, 7'h12, 4'h7});
    tbl.push_back('{16'h79DE, 1'b1, 0, 5, 7'h30, 4'hE});
    tbl.push_back('{16'h79DE, 1'b1, 1, 5, 7'h42, 4'hD});
    tbl.push_back('{16'h79DE, 1'b1, 2, 5, 7'h04, 4'hB});
    tbl.push_back('{16'h79DE, 1'b1, 3, 5, 7'h0F, 4'h7});

    // ---- reset state ----
    tick(); tick();
    chk("rst seg",  16'(seg), 16'h7F);
    chk("rst dig",  16'(dig_en), 16'hF);
    chk("rst ft",   16'(frame_tick), 16'h0);
    chk("rst seg1", 16'(seg1), 16'h00);
    chk("rst dig1", 16'(dig_en1), 16'h0);

    // ---- release: guard, digit 0 "0", first frame_tick ----
    @(negedge clk);
    rst_n = 1'b1;
    first_ft = 0; first_ft1 = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 1 || n == 2) begin
        chk($sformatf("rel%0d seg", n), 16'(seg), 16'h7F);
        chk($sformatf("rel%0d dig", n), 16'(dig_en), 16'hF);
        chk($sformatf("rel%0d seg1", n), 16'(seg1), 16'h00);
      end
      if (n == 3 || n == 8) begin
        chk($sformatf("rel%0d seg", n), 16'(seg), 16'h01);
        chk($sformatf("rel%0d dig", n), 16'(dig_en), 16'hE);
      end
      if (n == 3) begin
        chk("rel3 seg1", 16'(seg1), 16'h7E);
        chk("rel3 dig1", 16'(dig_en1), 16'h1);
      end
      if (n == 9) begin
        chk("rel9 seg", 16'(seg), 16'h7F);
        chk("rel9 dig", 16'(dig_en), 16'hF);
      end
      if (frame_tick  && first_ft  == 0) first_ft  = n;
      if (frame_tick1 && first_ft1 == 0) first_ft1 = n;
    end
    chk("first ft cycle",  16'(first_ft), 16'd32);
    chk("first ft1 cycle", 16'(first_ft1), 16'd8);

    // ---- table-driven vectors ----
    foreach (tbl[i]) begin
      lz_blank = tbl[i].lz;
      do_load(tbl[i].data);
      wait_frame();
      repeat (1 + 8 * tbl[i].slot + tbl[i].c) tick();
      chk($sformatf("vec%0d seg", i), 16'(seg), 16'(tbl[i].seg));
      chk($sformatf("vec%0d dig", i), 16'(dig_en), 16'(tbl[i].dig));
    end

    // ---- load mid-slot: new nibble one edge after capture ----
    lz_blank = 1'b0;
    do_load(16'h1A3F);
    wait_frame();
    repeat (4) tick();
    chk("midload pre seg", 16'(seg), 16'h38);
    data_in = 16'h1A35;
    load    = 1'b1;
    tick();
    load    = 1'b0;
    chk("midload cap seg", 16'(seg), 16'h38);
    chk("midload cap dig", 16'(dig_en), 16'hE);
    tick();
    chk("midload new seg", 16'(seg), 16'h24);
    chk("midload new dig", 16'(dig_en), 16'hE);

    // ---- blank mid-slot ----
    do_load(16'h1A3F);
    wait_frame();
    for (int n = 1; n <= 32; n++) begin
      tick();
      case (n)
        12: begin
          chk("blk pre seg", 16'(seg), 16'h06);
          chk("blk pre dig", 16'(dig_en), 16'hD);
          blank = 1'b1;
        end
        13: begin
          chk("blk on seg", 16'(seg), 16'h7F);
          chk("blk on dig", 16'(dig_en), 16'hF);
        end
        20: chk("blk mid dig", 16'(dig_en), 16'hF);
        29: begin
          chk("blk last dig", 16'(dig_en), 16'hF);
          blank = 1'b0;
        end
        30: begin
          chk("blk off seg", 16'(seg), 16'h4F);
          chk("blk off dig", 16'(dig_en), 16'h7);
        end
        31: chk("blk ft31", 16'(frame_tick), 16'h0);
        32: chk("blk ft32", 16'(frame_tick), 16'h1);
        default: ;
      endcase
    end

    // ---- single digit, active-high ----
    data_in1 = 4'h8;
    load1    = 1'b1;
    tick();
    load1    = 1'b0;
    got1 = 1'b0;
    for (int k = 0; k < 40 && !got1; k++) begin
      tick();
      got1 = frame_tick1;
    end
    chk("d1 align", 16'(got1), 16'h1);
    for (int c = 0; c < 8; c++) begin
      tick();
      chk($sformatf("d1 c%0d seg", c), 16'(seg1), (c >= 2) ? 16'h7F : 16'h00);
      chk($sformatf("d1 c%0d dig", c), 16'(dig_en1), (c >= 2) ? 16'h1 : 16'h0);
      chk($sformatf("d1 c%0d ft", c), 16'(frame_tick1), (c == 7) ? 16'h1 : 16'h0);
    end

    // ---- reset mid-scan ----
    do_load(16'h1A3F);
    wait_frame();
    repeat (22) tick();
    chk("mrst pre seg", 16'(seg), 16'h08);
    chk("mrst pre dig", 16'(dig_en), 16'hB);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst async seg", 16'(seg), 16'h7F);
    chk("mrst async dig", 16'(dig_en), 16'hF);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mrst r1 dig", 16'(dig_en), 16'hF);
    tick();
    chk("mrst r2 dig", 16'(dig_en), 16'hF);
    tick();
    chk("mrst r3 seg", 16'(seg), 16'h01);
    chk("mrst r3 dig", 16'(dig_en), 16'hE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
